// File: rtl/canvas_framebuffer.sv
// 28x28 grey-cell canvas: cell writes, a scaled RGB pixel pipeline (2 cycles, no stalls), a DNN read port (1 cycle)
// and a self-clearing sweep after reset or on iClear. Optional cell grid overlay when GRID_OVERLAY_EN is defined.
module canvas_framebuffer #(
  parameter int          CELLS       = 28,
  parameter int          SCALE_SHIFT = 4,
  parameter int          H_OFFSET    = 96,
  parameter int          V_OFFSET    = 16,
  parameter logic [11:0] BG_COLOR    = 12'h003
) (
  input  logic       iBusClk,
  input  logic       iRst,
  input  logic       iPixValid,
  input  logic [9:0] iPixX,
  input  logic [9:0] iPixY,
  output logic       oPixValid,
  output logic [3:0] oRed,
  output logic [3:0] oGreen,
  output logic [3:0] oBlue,
  input  logic       iWrEn,
  input  logic [4:0] iWrX,
  input  logic [4:0] iWrY,
  input  logic [3:0] iWrData,
  input  logic       iClear,
  output logic       oBusy,
  output logic       oClearDone,
  input  logic [9:0] iRdAddr,
  output logic [3:0] oRdData
);

  localparam int         DEPTH     = CELLS * CELLS;
  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);
  localparam logic [9:0] DEPTH_A   = 10'(DEPTH);
  localparam logic [9:0] CANVAS_PX = 10'(CELLS << SCALE_SHIFT);
  localparam logic [9:0] H_OFF     = 10'(H_OFFSET);
  localparam logic [9:0] V_OFF     = 10'(V_OFFSET);
  localparam logic [5:0] CELLS_V   = 6'(CELLS);

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} fbState_t;

  // row*CELLS+col as a constant-selected sum of shifted rows; no multiplier is built
  function automatic logic [9:0] cellAddr(input logic [4:0] cx, input logic [4:0] cy);
    logic [9:0] acc;
    acc = {5'd0, cx};
    for (int i = 0; i < 6; i++) begin
      if (CELLS_V[i]) acc = acc + ({5'd0, cy} << i);
    end
    return acc;
  endfunction

  fbState_t   state, stateNext;
  logic [9:0] clrCnt, clrCntNext;
  logic       clearDoneNext;

  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      state      <= ST_CLEAR;
      clrCnt     <= '0;
      oClearDone <= 1'b0;
    end else begin
      state      <= stateNext;
      clrCnt     <= clrCntNext;
      oClearDone <= clearDoneNext;
    end
  end

  always_comb begin
    stateNext     = state;
    clrCntNext    = clrCnt;
    clearDoneNext = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iClear) begin
          stateNext  = ST_CLEAR;
          clrCntNext = '0;
        end
      end
      ST_CLEAR: begin
        clrCntNext = clrCnt + 10'd1;
        if (clrCnt == LAST_ADDR) begin
          stateNext     = ST_IDLE;
          clrCntNext    = '0;
          clearDoneNext = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign oBusy = (state == ST_CLEAR);

  // Single write port: the sweep owns it while busy, drawing writes only land when idle and in range
  logic       wrAccept;
  logic       memWe;
  logic [9:0] memWAddr;
  logic [3:0] memWData;

  always_comb begin
    wrAccept = (state == ST_IDLE) && iWrEn
               && ({1'b0, iWrX} < CELLS_V) && ({1'b0, iWrY} < CELLS_V);
    memWe    = oBusy || wrAccept;
    memWAddr = oBusy ? clrCnt : cellAddr(iWrX, iWrY);
    memWData = oBusy ? 4'd0 : iWrData;
  end

  logic [3:0] mem [DEPTH];

  always_ff @(posedge iBusClk) begin
    if (memWe) mem[memWAddr] <= memWData;
  end

  // Stage 1: screen coordinate to cell address; negative offsets wrap and fall outside
  logic [9:0] dx, dy;
  logic       pixInside;
  logic [9:0] pixAddr;

  always_comb begin
    dx        = iPixX - H_OFF;
    dy        = iPixY - V_OFF;
    pixInside = (dx < CANVAS_PX) && (dy < CANVAS_PX);
    pixAddr   = pixInside ? cellAddr(5'(dx >> SCALE_SHIFT), 5'(dy >> SCALE_SHIFT)) : '0;
  end

  logic       p1Valid, p1Inside;
  logic [9:0] p1Addr;
  logic       p2Valid, p2Inside;
  logic [3:0] p2Cell;

  always_ff @(posedge iBusClk) begin
    if (iRst) begin
      p1Valid  <= 1'b0;
      p1Inside <= 1'b0;
      p2Valid  <= 1'b0;
      p2Inside <= 1'b0;
      oRdData  <= 4'd0;
    end else begin
      p1Valid  <= iPixValid;
      p1Inside <= pixInside;
      p2Valid  <= p1Valid;
      p2Inside <= p1Inside;
      oRdData  <= (iRdAddr < DEPTH_A) ? mem[iRdAddr] : 4'd0;
    end
  end

  // RAM read registers carry no reset; the reset valids mask them at the output
  always_ff @(posedge iBusClk) begin
    p1Addr <= pixAddr;
    p2Cell <= mem[p1Addr];
  end

  logic [3:0] cellShade;

`ifdef GRID_OVERLAY_EN
  logic pixEdge, p1Edge, p2Edge;

  assign pixEdge = (dx[SCALE_SHIFT-1:0] == '0) || (dy[SCALE_SHIFT-1:0] == '0);

  always_ff @(posedge iBusClk) begin
    p1Edge <= pixEdge;
    p2Edge <= p1Edge;
  end

  // Painted cells hide the grid line
  assign cellShade = ((p2Cell == 4'd0) && p2Edge) ? 4'h4 : p2Cell;
`else
  assign cellShade = p2Cell;
`endif

  always_comb begin
    oPixValid              = p2Valid;
    {oRed, oGreen, oBlue}  = 12'h000;
    if (p2Valid) begin
      {oRed, oGreen, oBlue} = p2Inside ? {cellShade, cellShade, cellShade} : BG_COLOR;
    end
  end

endmodule
